// File: rtl/sys_timer_master.sv
// rtl/sys_timer_master.sv - Avalon-MM master that programs and services the interval timer peripheral
// Optional snapshot readout of the timer counter: define SYS_TIMER_MASTER_SNAPSHOT_EN.
module sys_timer_master #(
  parameter logic [31:0] LOAD_VALUE = 32'd49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        irq,
  input  logic [15:0] readdata,
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
  input  logic        snap_req,
  output logic [31:0] snapshot,
  output logic        snapshot_valid,
`endif
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, ACK, STOP
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
    , SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        stop_pend_q, stop_pend_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [2:0]  address_q, address_d;
  logic        chipselect_q, chipselect_d;
  logic        write_n_q, write_n_d;
  logic [15:0] writedata_q, writedata_d;
  logic        tick_q, tick_d;
  logic        busy_q, busy_d;
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
  logic        snap_pend_q, snap_pend_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        snapshot_valid_q, snapshot_valid_d;
`else
  logic        unused_readdata;
  assign unused_readdata = ^readdata;
`endif

  always_comb begin
    state_d      = state_q;
    stop_pend_d  = stop_pend_q;
    tick_count_d = tick_count_q;
    if (state_q != IDLE && stop) stop_pend_d = 1'b1;
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
    snap_pend_d      = snap_pend_q;
    snapshot_d       = snapshot_q;
    snapshot_valid_d = (state_q == SNAP_CAP);
    if (state_q != IDLE && snap_req) snap_pend_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d      = WR_PL;
          tick_count_d = 32'd0;
          stop_pend_d  = 1'b0;
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
          snap_pend_d  = 1'b0;
`endif
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTRL;
      WR_CTRL: state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        // A pending timeout always wins so no interrupt is left unacknowledged.
        if (irq) begin
          state_d      = ACK;
          tick_count_d = tick_count_q + 32'd1;
        end else if (stop_pend_q) begin
          state_d = STOP;
        end
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
        else if (snap_pend_q) begin
          state_d = SNAP_WR;
        end
`endif
      end
      ACK: state_d = WAIT_IRQ;
      STOP: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
      SNAP_WR: state_d = SNAP_RL;
      SNAP_RL: state_d = SNAP_RH;
      SNAP_RH: begin
        state_d          = SNAP_CAP;
        snapshot_d[15:0] = readdata;
      end
      SNAP_CAP: begin
        state_d           = WAIT_IRQ;
        snapshot_d[31:16] = readdata;
        snap_pend_d       = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered copies of what the next state drives.
    chipselect_d = 1'b0;
    write_n_d    = 1'b1;
    address_d    = 3'd0;
    writedata_d  = 16'h0000;
    case (state_d)
      WR_PL:   begin chipselect_d = 1'b1; write_n_d = 1'b0; address_d = 3'd2; writedata_d = LOAD_VALUE[15:0]; end
      WR_PH:   begin chipselect_d = 1'b1; write_n_d = 1'b0; address_d = 3'd3; writedata_d = LOAD_VALUE[31:16]; end
      WR_CTRL: begin chipselect_d = 1'b1; write_n_d = 1'b0; address_d = 3'd1; writedata_d = 16'h0007; end
      ACK:     begin chipselect_d = 1'b1; write_n_d = 1'b0; address_d = 3'd0; end
      STOP:    begin chipselect_d = 1'b1; write_n_d = 1'b0; address_d = 3'd1; writedata_d = 16'h0008; end
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
      SNAP_WR: begin chipselect_d = 1'b1; write_n_d = 1'b0; address_d = 3'd4; end
      SNAP_RL: begin chipselect_d = 1'b1; address_d = 3'd4; end
      SNAP_RH: begin chipselect_d = 1'b1; address_d = 3'd5; end
`endif
      default: ;
    endcase
    tick_d = (state_d == ACK);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      stop_pend_q      <= 1'b0;
      tick_count_q     <= 32'd0;
      address_q        <= 3'd0;
      chipselect_q     <= 1'b0;
      write_n_q        <= 1'b1;
      writedata_q      <= 16'h0000;
      tick_q           <= 1'b0;
      busy_q           <= 1'b0;
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
      snap_pend_q      <= 1'b0;
      snapshot_q       <= 32'd0;
      snapshot_valid_q <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      stop_pend_q      <= stop_pend_d;
      tick_count_q     <= tick_count_d;
      address_q        <= address_d;
      chipselect_q     <= chipselect_d;
      write_n_q        <= write_n_d;
      writedata_q      <= writedata_d;
      tick_q           <= tick_d;
      busy_q           <= busy_d;
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
      snap_pend_q      <= snap_pend_d;
      snapshot_q       <= snapshot_d;
      snapshot_valid_q <= snapshot_valid_d;
`endif
    end
  end

  assign address    = address_q;
  assign chipselect = chipselect_q;
  assign write_n    = write_n_q;
  assign writedata  = writedata_q;
  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign busy       = busy_q;
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
  assign snapshot       = snapshot_q;
  assign snapshot_valid = snapshot_valid_q;
`endif

endmodule

// File: tb/tb_sys_timer_master.sv
// tb/tb_sys_timer_master.sv - scoreboard bench for sys_timer_master with a behavioural timer model
module tb_sys_timer_master;
  localparam logic [31:0] LV = 32'd9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] readdata = 16'h0000;
  logic [2:0]  address;
  logic        chipselect, write_n, tick, busy;
  logic [15:0] writedata;
  logic [31:0] tick_count;
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
  logic        snap_req = 1'b0;
  logic [31:0] snapshot;
  logic        snapshot_valid;
`endif

  sys_timer_master #(.LOAD_VALUE(LV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .irq(irq), .readdata(readdata),
`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
    .snap_req(snap_req), .snapshot(snapshot), .snapshot_valid(snapshot_valid),
`endif
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .tick(tick), .tick_count(tick_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Entry: {cycle, write_n, address, writedata (0 for reads), tick}
  typedef logic [52:0] acc_t;
  acc_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          ticks_seen = 0;
  logic [31:0] cyc = 0;
  logic        running = 1'b0;
  int          tcnt = 0;
  logic [31:0] snap_reg = 32'd0;
  int          exp_cnt = 0;

  function automatic acc_t mk(logic [31:0] c, logic wn, logic [2:0] a, logic [15:0] d, logic t);
    return {c, wn, a, d, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timer model: interrupts every LV+1 cycles once started; ACK write clears irq.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chipselect && !write_n) begin
      if (address == 3'd1 && writedata[2]) begin running <= 1'b1; tcnt <= 0; end
      else if (address == 3'd1 && writedata[3]) running <= 1'b0;
      if (address == 3'd0) irq <= 1'b0;
      if (address == 3'd4) snap_reg <= 32'h0001_2345;
    end
    if (running && !(chipselect && !write_n && address == 3'd1)) begin
      if (tcnt == int'(LV)) begin
        tcnt <= 0;
        irq  <= 1'b1;
        sb.push_back(mk(cyc + 2, 1'b0, 3'd0, 16'h0000, 1'b1));
      end else begin
        tcnt <= tcnt + 1;
      end
    end
    if (chipselect && write_n)
      readdata <= (address == 3'd4) ? snap_reg[15:0] : (address == 3'd5) ? snap_reg[31:16] : 16'h0000;
    else
      readdata <= 16'h0000;
  end

  always @(negedge clk) begin
    if (reset_n && (chipselect || tick)) begin
      if (tick) ticks_seen++;
      if (sb.size() == 0) chk("sb_empty_on_access", sb.size(), 1);
      else chk("bus_access", {cyc, write_n, address, (write_n ? 16'h0000 : writedata), tick}, sb.pop_front());
    end
  end

  task automatic do_start();
    start = 1'b1;
    sb.push_back(mk(cyc + 1, 1'b0, 3'd2, LV[15:0], 1'b0));
    sb.push_back(mk(cyc + 2, 1'b0, 3'd3, LV[31:16], 1'b0));
    sb.push_back(mk(cyc + 3, 1'b0, 3'd1, 16'h0007, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = ticks_seen + n;
    for (int i = 0; i < n * 12 + 20; i++) begin
      @(negedge clk); #1;
      if (ticks_seen >= target) break;
    end
    chk("tick_wait", ticks_seen, target);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_chipselect"}, chipselect, 0);
    chk({tag, "_write_n"}, write_n, 1);
    chk({tag, "_writedata"}, writedata, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_tick_count"}, tick_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic found;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);

    do_start();
    chk("busy_after_start", busy, 1);
    wait_ticks(5);
    exp_cnt = 5;
    chk("tick_count_5", tick_count, exp_cnt);

    // start while busy must not trigger a rewrite of the period
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ticks(1);
    exp_cnt = 6;
    chk("tick_count_6", tick_count, exp_cnt);

    @(posedge clk); #1;
    force dut.tick_count_d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.tick_count_d;
    chk("tick_count_forced", tick_count, 32'hFFFF_FFFF);
    wait_ticks(1);
    exp_cnt = 0;
    chk("tick_count_wrap", tick_count, exp_cnt);

`ifdef SYS_TIMER_MASTER_SNAPSHOT_EN
    begin
      logic [31:0] c0;
      logic        seen;
      @(posedge clk); #1;
      c0 = cyc;
      snap_req = 1'b1;
      sb.push_back(mk(c0 + 2, 1'b0, 3'd4, 16'h0000, 1'b0));
      sb.push_back(mk(c0 + 3, 1'b1, 3'd4, 16'h0000, 1'b0));
      sb.push_back(mk(c0 + 4, 1'b1, 3'd5, 16'h0000, 1'b0));
      @(posedge clk); #1;
      snap_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (snapshot_valid) begin seen = 1'b1; break; end
      end
      chk("snap_valid_seen", seen, 1);
      chk("snap_valid_cycle", cyc, c0 + 6);
      chk("snapshot_value", snapshot, 32'h0001_2345);
      @(negedge clk);
      chk("snap_valid_one_cycle", snapshot_valid, 0);
      drain();
    end
`endif

    // stop in the same cycle as a fresh irq
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (irq) begin found = 1'b1; break; end
    end
    chk("irq_seen_for_stop", found, 1);
    stop = 1'b1;
    sb.push_back(mk(cyc + 3, 1'b0, 3'd1, 16'h0008, 1'b0));
    @(posedge clk); #1;
    stop = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("busy_after_stop", busy, 0);
    chk("tick_count_after_stop", tick_count, exp_cnt + 1);

    // reset asserted during WR_PH
    do_start();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    drain();
    chk("busy_after_restart", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
